// File: rtl/uart_bytes_tx.sv
`default_nettype none
// ============================================================================
//  Module   : uart_bytes_tx
//  Purpose  : UART packet transmitter. A packet is one header frame
//             {rw_flag, 1'b1, target_mem_type, target_addr}. A write packet
//             also carries BYTE_COUNT payload frames {4'b0000, byte}, sent
//             MSB byte first. Each frame is 1 start bit, DATA_BITS data bits
//             sent LSB first, and 1 stop bit. Every bit lasts CLKS_PER_BIT
//             cycles.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_bytes_tx #(
    parameter int BYTE_COUNT   = 4,
    parameter int DATA_BITS    = 12,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        rw_flag,
    input  logic        target_mem_type,
    input  logic [8:0]  target_addr,
    input  logic [31:0] data_in,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    // ------------------------------------------------------------------------
    // Counter widths and terminal values
    // ------------------------------------------------------------------------
    localparam int c_BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int c_BIT_W  = $clog2(DATA_BITS + 2);
    localparam int c_BYTE_W = (BYTE_COUNT > 1) ? $clog2(BYTE_COUNT) : 1;

    localparam logic [c_BAUD_W-1:0] c_LAST_BAUD = c_BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [c_BIT_W-1:0]  c_STOP_BIT  = c_BIT_W'(DATA_BITS + 1);
    localparam logic [c_BYTE_W-1:0] c_LAST_BYTE = c_BYTE_W'(BYTE_COUNT - 1);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [1:0] c_IDLE        = 2'd0;
    localparam logic [1:0] c_SEND_HEADER = 2'd1;
    localparam logic [1:0] c_SEND_BYTE   = 2'd2;
    localparam logic [1:0] c_DONE        = 2'd3;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [1:0]          r_state;
    logic [c_BAUD_W-1:0] r_baud_cnt;   // cycle position inside the current bit
    logic [c_BIT_W-1:0]  r_bit_cnt;    // 0 = start bit, DATA_BITS+1 = stop bit
    logic [c_BYTE_W-1:0] r_byte_cnt;   // payload byte being sent
    logic                r_rw;
    logic                r_mem;
    logic [8:0]          r_addr;
    logic [31:0]         r_data;
    logic                r_tx;
    logic                r_busy;
    logic                r_done;

    // ------------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------------
    logic [1:0]           w_state_nxt;
    logic [c_BAUD_W-1:0]  w_baud_nxt;
    logic [c_BIT_W-1:0]   w_bit_nxt;
    logic [c_BYTE_W-1:0]  w_byte_nxt;
    logic                 w_sending;
    logic                 w_sending_nxt;
    logic                 w_accept;
    logic                 w_bit_end;
    logic                 w_frame_end;
    logic                 w_last_byte;
    logic [7:0]           w_byte_sel;
    logic [DATA_BITS-1:0] w_header;
    logic [DATA_BITS-1:0] w_payload;
    logic [DATA_BITS+1:0] w_frame_bits;
    logic                 w_tx_nxt;
    logic                 w_busy_nxt;
    logic                 w_done_nxt;

    assign w_sending   = (r_state == c_SEND_HEADER) || (r_state == c_SEND_BYTE);
    assign w_accept    = (r_state == c_IDLE) && start;
    assign w_bit_end   = (r_baud_cnt == c_LAST_BAUD);
    assign w_frame_end = w_sending && w_bit_end && (r_bit_cnt == c_STOP_BIT);
    assign w_last_byte = (r_byte_cnt == c_LAST_BYTE);

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode: header, then payload only for writes, then one DONE cycle
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (start) begin
                    w_state_nxt = c_SEND_HEADER;
                end
            end
            c_SEND_HEADER: begin
                if (w_frame_end) begin
                    w_state_nxt = r_rw ? c_SEND_BYTE : c_DONE;
                end
            end
            c_SEND_BYTE: begin
                if (w_frame_end && w_last_byte) begin
                    w_state_nxt = c_DONE;
                end
            end
            c_DONE: begin
                w_state_nxt = c_IDLE;
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    // Next counter values; frames run back-to-back, so the start bit follows the stop bit directly
    always_comb begin
        w_baud_nxt = '0;
        w_bit_nxt  = '0;
        w_byte_nxt = '0;
        if (w_sending) begin
            w_byte_nxt = r_byte_cnt;
            if (w_frame_end) begin
                if ((r_state == c_SEND_BYTE) && !w_last_byte) begin
                    w_byte_nxt = r_byte_cnt + c_BYTE_W'(1);
                end else begin
                    w_byte_nxt = '0;
                end
            end else if (w_bit_end) begin
                w_bit_nxt = r_bit_cnt + c_BIT_W'(1);
            end else begin
                w_bit_nxt  = r_bit_cnt;
                w_baud_nxt = r_baud_cnt + c_BAUD_W'(1);
            end
        end
    end

    // Counters and the request latch; inputs are captured only when a packet is accepted
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
            r_byte_cnt <= '0;
            r_rw       <= 1'b0;
            r_mem      <= 1'b0;
            r_addr     <= '0;
            r_data     <= '0;
        end else begin
            r_baud_cnt <= w_baud_nxt;
            r_bit_cnt  <= w_bit_nxt;
            r_byte_cnt <= w_byte_nxt;
            if (w_accept) begin
                r_rw   <= rw_flag;
                r_mem  <= target_mem_type;
                r_addr <= target_addr;
                r_data <= data_in;
            end
        end
    end

    // Payload byte for the upcoming cycle: byte 0 is data[31:24], then downwards
    always_comb begin
        w_byte_sel = r_data[31:24];
        for (int k = 0; k < BYTE_COUNT; k++) begin
            if (w_byte_nxt == c_BYTE_W'(k)) begin
                w_byte_sel = r_data[31 - 8*k -: 8];
            end
        end
    end

    // Frame word framed by start (LSB) and stop (MSB) bits so the bit counter indexes it directly
    always_comb begin
        w_header       = '0;
        w_header[11:0] = {r_rw, 1'b1, r_mem, r_addr};
        w_payload      = '0;
        w_payload[7:0] = w_byte_sel;
        if (w_state_nxt == c_SEND_BYTE) begin
            w_frame_bits = {1'b1, w_payload, 1'b0};
        end else begin
            w_frame_bits = {1'b1, w_header, 1'b0};
        end
    end

    // Output decode from the next state so tx, busy and done come straight from flops.
    // On the accepting edge the header latch is not loaded yet, but bit 0 is the
    // start bit, which does not depend on it.
    assign w_sending_nxt = (w_state_nxt == c_SEND_HEADER) || (w_state_nxt == c_SEND_BYTE);

    always_comb begin
        w_tx_nxt   = 1'b1;
        w_busy_nxt = (w_state_nxt != c_IDLE);
        w_done_nxt = (w_state_nxt == c_DONE);
        if (w_sending_nxt) begin
            w_tx_nxt = w_frame_bits[w_bit_nxt];
        end
    end

    // Output registers; reset forces the line idle immediately, aborting any frame
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_tx   <= 1'b1;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_tx   <= w_tx_nxt;
            r_busy <= w_busy_nxt;
            r_done <= w_done_nxt;
        end
    end

    assign tx   = r_tx;
    assign busy = r_busy;
    assign done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_uart_bytes_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_bytes_tx
//  Purpose  : Randomised scoreboard bench for uart_bytes_tx. The driver
//             predicts frames, done pulses, busy windows and decoded packets
//             from the packet format; a monitor deserialises tx and compares.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_bytes_tx;

    localparam int CPB   = 4;
    localparam int DB    = 12;
    localparam int BC    = 4;
    localparam int FRAME = (DB + 2) * CPB;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        rw_flag = 1'b0;
    logic        target_mem_type = 1'b0;
    logic [8:0]  target_addr = '0;
    logic [31:0] data_in = '0;
    logic        tx;
    logic        busy;
    logic        done;

    uart_bytes_tx #(
        .BYTE_COUNT  (BC),
        .DATA_BITS   (DB),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .rw_flag        (rw_flag),
        .target_mem_type(target_mem_type),
        .target_addr    (target_addr),
        .data_in        (data_in),
        .tx             (tx),
        .busy           (busy),
        .done           (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    typedef struct { int t; int v; } frame_t;
    typedef struct { int lo; int hi; } win_t;
    typedef struct { bit rw; bit mem; int addr; bit [31:0] data; } pkt_t;

    frame_t frame_q[$];
    int     done_q[$];
    win_t   busy_q[$];
    pkt_t   pkt_q[$];

    int tests = 0;
    int fails = 0;
    int rst_cyc = -1;

    task automatic chk(string name, longint act, longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(string name, string msg);
        tests++;
        fails++;
        $display("FAIL %s: %s (cycle %0d)", name, msg, cyc);
    endtask

    // Reference model: what a packet accepted on edge p must look like on the line
    task automatic expect_packet(bit rw, bit mem, int addr, bit [31:0] data, int p, output int dcyc);
        frame_t f;
        pkt_t   k;
        int     n;
        n   = rw ? (1 + BC) : 1;
        f.t = p;
        f.v = (int'(rw) << 11) + (1 << 10) + (int'(mem) << 9) + addr;
        frame_q.push_back(f);
        if (rw) begin
            for (int b = 0; b < BC; b++) begin
                f.t = p + FRAME * (b + 1);
                f.v = int'((data >> (8 * (BC - 1 - b))) & 32'hFF);
                frame_q.push_back(f);
            end
        end
        dcyc = p + FRAME * n;
        done_q.push_back(dcyc);
        busy_q.push_back('{lo: p, hi: dcyc});
        k.rw   = rw;
        k.mem  = mem;
        k.addr = addr;
        k.data = rw ? data : 32'h0;
        pkt_q.push_back(k);
    endtask

    // ---------------- monitor ----------------
    logic [FRAME-1:0] samp;
    int scnt = 0;
    bit in_frame = 0;
    int fstart = 0;
    bit asm_act = 0;
    bit a_rw, a_mem;
    int a_addr, a_cnt;
    bit [31:0] a_data;

    task automatic pkt_done();
        pkt_t e;
        if (pkt_q.size() == 0) begin
            fail_now("pkt_unexpected", "decoded packet with none expected");
        end else begin
            e = pkt_q.pop_front();
            chk("rx_rw_flag", a_rw, e.rw);
            chk("rx_mem_type", a_mem, e.mem);
            chk("rx_target_addr", a_addr, e.addr);
            if (e.rw) chk("rx_data_out", a_data, e.data);
        end
    endtask

    task automatic assemble(int v);
        if (!asm_act) begin
            if (((v >> 10) & 1) == 0) begin
                fail_now("pkt_no_header", "payload-looking frame where a header was due");
            end else begin
                a_rw   = v[11];
                a_mem  = v[9];
                a_addr = v & 32'h1FF;
                a_data = '0;
                a_cnt  = 0;
                if (a_rw) asm_act = 1;
                else pkt_done();
            end
        end else begin
            chk("payload_pad", v >> 8, 0);
            a_data = (a_data << 8) | 32'(v & 32'hFF);
            a_cnt++;
            if (a_cnt == BC) begin
                asm_act = 0;
                pkt_done();
            end
        end
    endtask

    task automatic finish_frame();
        bit     ok;
        int     v;
        frame_t f;
        ok = 1;
        for (int b = 0; b < DB + 2; b++)
            for (int j = 1; j < CPB; j++)
                if (samp[b*CPB + j] != samp[b*CPB]) ok = 0;
        chk("bit_timing", ok, 1);
        chk("stop_bit", samp[(DB+1)*CPB], 1);
        v = 0;
        for (int i = 0; i < DB; i++) v = v | (int'(samp[(i+1)*CPB]) << i);
        if (frame_q.size() == 0) begin
            $display("FAIL frame_unexpected: got frame 0x%0h at cycle %0d, expected none", v, fstart);
            tests++;
            fails++;
        end else begin
            f = frame_q.pop_front();
            chk("frame_start_cycle", fstart, f.t);
            chk("frame_value", v, f.v);
        end
        assemble(v);
        in_frame = 0;
    endtask

    always @(negedge clk) begin
        bit exp_b;
        if (cyc == rst_cyc) begin
            frame_q.delete();
            done_q.delete();
            busy_q.delete();
            pkt_q.delete();
            in_frame = 0;
            asm_act  = 0;
            chk("reset_abort_tx", tx, 1);
            chk("reset_abort_busy", busy, 0);
            chk("reset_abort_done", done, 0);
        end
        // busy window
        while (busy_q.size() > 0 && busy_q[0].hi < cyc) void'(busy_q.pop_front());
        exp_b = (busy_q.size() > 0) && (busy_q[0].lo <= cyc);
        chk("busy", busy, exp_b);
        // done pulse
        while (done_q.size() > 0 && done_q[0] < cyc) begin
            fail_now("done_missing", $sformatf("no done pulse at expected cycle %0d", done_q[0]));
            void'(done_q.pop_front());
        end
        if (done === 1'b1) begin
            if (done_q.size() == 0) fail_now("done_unexpected", "done pulse with none expected");
            else chk("done_cycle", cyc, done_q.pop_front());
        end
        // serial line
        if (in_frame) begin
            samp[scnt] = tx;
            scnt++;
            if (scnt == FRAME) finish_frame();
        end else if (tx == 1'b0) begin
            in_frame = 1;
            fstart   = cyc;
            samp     = '0;
            samp[0]  = tx;
            scnt     = 1;
        end
        if (!in_frame) begin
            while (frame_q.size() > 0 && frame_q[0].t < cyc) begin
                fail_now("frame_missing", $sformatf("no start bit at expected cycle %0d", frame_q[0].t));
                void'(frame_q.pop_front());
            end
        end
    end

    // ---------------- driver ----------------
    task automatic rand_inputs();
        rw_flag         = 1'($urandom);
        target_mem_type = 1'($urandom);
        target_addr     = 9'($urandom);
        data_in         = $urandom;
    endtask

    task automatic issue(bit rw, bit mem, logic [8:0] a, logic [31:0] d, output int dcyc);
        rw_flag         = rw;
        target_mem_type = mem;
        target_addr     = a;
        data_in         = d;
        start           = 1'b1;
        expect_packet(rw, mem, int'(a), d, cyc + 1, dcyc);
        @(negedge clk);
        start = 1'b0;
        rand_inputs();
    endtask

    // Wait out a packet while toggling inputs and stray start pulses that must be ignored
    task automatic wait_with_noise(int c);
        while (cyc < c) begin
            start = (cyc < c - 1) && ($urandom_range(0, 19) == 0);
            rand_inputs();
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    initial begin
        int d, d1, d2, p;
        // reset with start asserted: must be ignored
        reset = 1'b0;
        start = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_tx", tx, 1);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        reset = 1'b1;
        start = 1'b0;
        repeat (2) @(negedge clk);

        // directed write and read packets
        issue(1'b1, 1'b1, 9'h005, 32'hDEADBEEF, d);
        wait_with_noise(d + 1);
        issue(1'b0, 1'b0, 9'h1FF, 32'h12345678, d);
        wait_with_noise(d + 1);

        // random packets with random idle gaps
        for (int i = 0; i < 8; i++) begin
            repeat ($urandom_range(0, 4)) @(negedge clk);
            issue(1'($urandom), 1'($urandom), 9'($urandom), $urandom, d);
            wait_with_noise(d + 1);
        end

        // start held high, inputs changing mid-packet
        rw_flag = 1'b1; target_mem_type = 1'b0; target_addr = 9'h0A5; data_in = 32'hCAFEF00D;
        start = 1'b1;
        expect_packet(1'b1, 1'b0, 9'h0A5, 32'hCAFEF00D, cyc + 1, d1);
        @(negedge clk);
        while (cyc < d1 + 1) begin
            rand_inputs();
            @(negedge clk);
        end
        rw_flag = 1'b0; target_mem_type = 1'b1; target_addr = 9'h13C; data_in = 32'h0;
        expect_packet(1'b0, 1'b1, 9'h13C, 32'h0, d1 + 2, d2);
        @(negedge clk);
        start = 1'b0;
        rand_inputs();
        wait_with_noise(d2 + 1);

        // reset during the second payload frame, with start asserted during reset
        issue(1'b1, 1'($urandom), 9'($urandom), $urandom, d);
        p = d - FRAME * (1 + BC);
        while (cyc < p + 2 * FRAME + $urandom_range(1, FRAME - 2)) @(negedge clk);
        rst_cyc = cyc + 1;
        reset   = 1'b0;
        start   = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        start = 1'b0;
        repeat (FRAME * 3) @(negedge clk);

        // recovery packet
        issue(1'b1, 1'($urandom), 9'($urandom), $urandom, d);
        wait_with_noise(d + 1);
        repeat (10) @(negedge clk);

        chk("frames_outstanding", frame_q.size(), 0);
        chk("done_outstanding", done_q.size(), 0);
        chk("pkts_outstanding", pkt_q.size(), 0);
        chk("frame_in_progress", in_frame, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation still running at time limit, expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/uart_bytes_tx.md
UART_BYTES_TX -- requirements
Module: uart_bytes_tx

Interface
REQ-001 SHALL have parameter BYTE_COUNT, default 4: number of payload bytes sent after a write header.
REQ-002 SHALL have parameter DATA_BITS, default 12: data bits per serial frame.
REQ-003 SHALL have parameter CLKS_PER_BIT, default 868: clk cycles per bit (100 MHz / 115200 baud).
REQ-004 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1: one clock; reset is synchronous and active-low.
REQ-006 SHALL have port start, input, 1: request to send one packet; sampled only in IDLE.
REQ-007 SHALL have port rw_flag, input, 1: 1 = write packet (header plus payload), 0 = read request (header only).
REQ-008 SHALL have port target_mem_type, input, 1: memory select, placed in header bit 9.
REQ-009 SHALL have port target_addr, input, 9: target address, placed in header bits 8:0.
REQ-010 SHALL have port data_in, input, 32: write payload; data_in[31:24] is sent first.
REQ-011 SHALL have port tx, output, 1: UART serial line; idle high.
REQ-012 SHALL have port busy, output, 1: high from the cycle after start is accepted through the DONE cycle.
REQ-013 SHALL have port done, output, 1: one-cycle pulse when the packet is complete.

Function
REQ-014 SHALL serialise each frame as 1 start bit (0), then DATA_BITS data bits LSB first, then 1 stop bit (1); each bit lasts exactly CLKS_PER_BIT cycles; a frame lasts (DATA_BITS+2)*CLKS_PER_BIT cycles.
REQ-015 SHALL build the header frame as {rw_flag, 1'b1, target_mem_type, target_addr}: 2'b11 in bits 11:10 for a write, 2'b01 for a read.
REQ-016 SHALL build each payload frame as {4'b0000, byte}, with bytes taken in order data_in[31:24], [23:16], [15:8], [7:0] for BYTE_COUNT=4 (generally MSB byte first).
REQ-017 SHALL implement the states IDLE, SEND_HEADER, SEND_BYTE and DONE.
REQ-018 SHALL, in IDLE with start=1, latch every request input into internal registers, set busy, and enter SEND_HEADER.
REQ-019 SHALL drive the start bit of the header frame on tx beginning the cycle after start is sampled.
REQ-020 SHALL ignore request-input changes after latching and ignore start outside IDLE; a held-high start SHALL begin a new packet only after the DONE cycle.
REQ-021 SHALL, at the end of the header stop bit, go to SEND_BYTE when rw_flag=1 and to DONE when rw_flag=0.
REQ-022 SHALL send payload frames back-to-back with no idle gap, using a byte counter from 0 to BYTE_COUNT-1, and go to DONE after the stop bit of byte BYTE_COUNT-1.
REQ-023 SHALL, in DONE, hold tx=1, assert done=1 for exactly one cycle with busy=1, then return to IDLE with busy=0.
REQ-024 SHALL start the next start bit, for consecutive frames, on the cycle immediately after the previous stop bit's last cycle.
REQ-025 SHALL register tx so that it is glitch-free and never X after reset.

Reset
REQ-026 SHALL, when reset=0 at a clock edge, return to IDLE and clear the bit, baud and byte counters and the latched registers; outputs SHALL be tx=1, busy=0, done=0.
REQ-027 SHALL, on reset mid-frame, abort transmission and drive tx=1 from the next edge, sending no partial remainder after reset is released.
REQ-028 SHALL ignore start while reset=0.

Verification (bench uses CLKS_PER_BIT=4, DATA_BITS=12, BYTE_COUNT=4)
REQ-029 SHALL cover a write packet: rw_flag=1, target_mem_type=1, target_addr=0x005, data_in=0xDEADBEEF, start pulse -> tx frames 0xE05, 0x0DE, 0x0AD, 0x0BE, 0x0EF, back-to-back with 56 cycles per frame; done pulses once 281 cycles after start is sampled.
REQ-030 SHALL cover a read packet: rw_flag=0, target_mem_type=0, target_addr=0x1FF -> single frame 0x5FF; done 57 cycles after start; no payload frames.
REQ-031 SHALL cover a loopback test: tx wired to UART_Bytes_RX with the same parameters -> receiver reports data_out=0xDEADBEEF, target_addr=0x005, target_mem_type=1, rw_flag=1 for the write packet.
REQ-032 SHALL cover start held high and inputs changed mid-packet -> the first packet uses the latched values; a second packet begins the cycle after the DONE cycle.
REQ-033 SHALL cover reset=0 asserted during the second payload frame -> tx=1, busy=0 next cycle; no done pulse; line stays idle until the next start.
REQ-034 SHALL cover a bit-timing check -> every tx transition is an integer multiple of 4 cycles from the start-bit falling edge, and the stop bit is high for 4 cycles.
